// File: rtl/am2950q_xcvr.sv
// rtl/am2950q_xcvr.sv - registered bidirectional bus transceiver with per-direction FIFOs
// Two independent strobe-driven FIFOs (A->B, B->A) behind tristate bus drivers.

module am2950q_xcvr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             load_n_i,
  input  logic             pop_n_i,
  output logic [WIDTH-1:0] head_o,
  output logic             nempty_o,
  output logic             full_o,
  output logic             err_o
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             nempty_q, full_q;
  logic             is_empty, is_full, do_load, do_pop;

  // Explicit wrap keeps DEPTH=1 (AW forced to 1) pinned at slot 0.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  always_comb begin
    is_empty = (cnt_q == '0);
    is_full  = (cnt_q == FULL_CNT);
    do_pop   = !pop_n_i && !is_empty;
    // A pop in the same cycle frees the slot, so a load at full still lands.
    do_load  = !load_n_i && (!is_full || do_pop);
    err_o    = (!load_n_i && !do_load) || (!pop_n_i && is_empty);
    wr_d     = do_load ? ptr_inc(wr_q) : wr_q;
    rd_d     = do_pop  ? ptr_inc(rd_q) : rd_q;
    case ({do_load, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      nempty_q <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      nempty_q <= (cnt_d != '0);
      full_q   <= (cnt_d == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_load) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  assign head_o   = mem_q[rd_q];
  assign nempty_o = nempty_q;
  assign full_o   = full_q;

endmodule

module am2950q_xcvr #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  input  logic             lda_,
  input  logic             rdb_,
  input  logic             oeb_,
  input  logic             ldb_,
  input  logic             rda_,
  input  logic             oea_,
  output logic             fab,
  output logic             fullab,
  output logic             fba,
  output logic             fullba,
  output logic             err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] head_ab, head_ba;
  logic             err_ab, err_ba;
  logic             err_q, err_d;

  am2950q_xcvr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo_ab (
    .clk      (clk),
    .rst      (rst),
    .wdata_i  (a),
    .load_n_i (lda_),
    .pop_n_i  (rdb_),
    .head_o   (head_ab),
    .nempty_o (fab),
    .full_o   (fullab),
    .err_o    (err_ab)
  );

  am2950q_xcvr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo_ba (
    .clk      (clk),
    .rst      (rst),
    .wdata_i  (b),
    .load_n_i (ldb_),
    .pop_n_i  (rda_),
    .head_o   (head_ba),
    .nempty_o (fba),
    .full_o   (fullba),
    .err_o    (err_ba)
  );

  assign err_d = err_q | err_ab | err_ba;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

  // An empty FIFO drives zeros rather than stale storage.
  assign b = oeb_ ? {WIDTH{1'bz}} : (fab ? head_ab : {WIDTH{1'b0}});
  assign a = oea_ ? {WIDTH{1'bz}} : (fba ? head_ba : {WIDTH{1'b0}});

endmodule

// File: doc/am2950q_xcvr.md
Name: am2950q_xcvr

Overview:
- Parametrised registered bidirectional bus transceiver, the successor to the combinational tristate transceivers (am2947 family).
- Each direction (A→B, B→A) has its own DEPTH-entry FIFO, so data can be captured from one bus and handed off later on the other.
- Provides per-direction status flags and an active-low strobe handshake, in the style of the Am2950 bidirectional I/O port.
- Sits between a microprogram data bus and a system bus.

Parameters:
- WIDTH, 8, data bits per bus.
- DEPTH, 4, entries per direction FIFO; power of 2, >=1.
- AW, $clog2(DEPTH) (min 1), FIFO pointer width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- a  inout  WIDTH  A-side bus.
- b  inout  WIDTH  B-side bus.
- lda_  input  1  active-low; load a into A→B FIFO.
- rdb_  input  1  active-low; pop A→B FIFO (B side consumed head).
- oeb_  input  1  active-low; drive b with A→B head.
- ldb_  input  1  active-low; load b into B→A FIFO.
- rda_  input  1  active-low; pop B→A FIFO.
- oea_  input  1  active-low; drive a with B→A head.
- fab  output  1  A→B FIFO not empty.
- fullab  output  1  A→B FIFO full.
- fba  output  1  B→A FIFO not empty.
- fullba  output  1  B→A FIFO full.
- err  output  1  sticky overflow/underflow flag, either direction.

Behaviour:
- Both directions are identical and independent. Described for A→B; B→A mirrors it (ldb_/rda_/oea_/fba/fullba).
- Synchronous reset (rst=1 at clk edge):
  - pointers and count cleared; fab=0, fullab=0, fba=0, fullba=0, err=0.
  - FIFO storage contents are don't-care.
  - Reset overrides any strobe in the same cycle, including mid-transfer; queued data is discarded.
- Load: lda_=0 and not full at the edge → the value on pin a is written at the tail, and count+1 is visible after that edge.
- Pop: rdb_=0 and not empty at the edge → head advances; count-1.
- Load and pop in the same cycle:
  - not empty and not full: both occur, count unchanged.
  - full: both occur; the pop frees the slot, fullab stays 1, no error.
  - empty: the load occurs, the pop is ignored, err is set.
- Load while full without a pop: word dropped, err set.
- Pop while empty: ignored, err set.
- err stays 1 until rst.
- Flags are registered and valid one cycle after the causing edge: fab = (count!=0), fullab = (count==DEPTH).
- Pointers wrap modulo DEPTH. The count is AW+1 bits wide to distinguish full from empty.
- Output drive (combinational, no clock latency):
  - b = head word when oeb_=0 and fab=1.
  - b = all zeros when oeb_=0 and empty.
  - b = high-Z when oeb_=1.
  - a is driven the same way from the B→A FIFO under oea_.
- Loopback: loading from a pin the block itself is driving samples the driven value; this is legal and not an error.
- Bus contention with an external driver is the system's responsibility. The block does not arbitrate between oea_ and oeb_; both may be active at once.
- DEPTH=1 degenerates to a single register with a full/empty flag, i.e. Am2950 behaviour.

Test Plan:
- Reset/tristate: rst=1 one cycle, all strobes high → a=b=ZZZZZZZZ, fab=fba=fullab=fullba=err=0.
- A→B fill: drive a=00110011, 01010101, 11110000, 00001111 with lda_=0 for four edges → fullab=1 after 4th edge. Then oeb_=0 → b=00110011. Three rdb_ pops → b shows 01010101, 11110000, 00001111 in order; fab=1 throughout, fullab=0 after the first pop.
- Overflow: with A→B full, lda_=0 and a=11111111 alone → err=1, count unchanged. After draining four, the fifth pop → err stays 1 and b drives 00000000 with oeb_=0.
- Simultaneous at full: A→B full, lda_=0 and rdb_=0 together with a=10101010 → fullab stays 1, err stays 0. After draining, the last word read is 10101010.
- B→A independence: load b=10101010 via ldb_ while A→B holds data; oea_=0 → a=10101010, fba=1, A→B count untouched.
- Mid-operation reset: two words queued in each direction, assert rst with lda_=0 → next cycle all flags 0 and a/b high-Z with oe_ high.
